// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the two-road intersection controller.
// Lamps are {Red, Yellow, Green}; each road normally shows exactly one bit.
package traffic_pkg;

  typedef enum logic [2:0] {
    PHASE_MAIN_G   = 3'd0,
    PHASE_MAIN_Y   = 3'd1,
    PHASE_ALLRED_A = 3'd2,
    PHASE_SIDE_G   = 3'd3,
    PHASE_SIDE_Y   = 3'd4,
    PHASE_ALLRED_B = 3'd5,
    PHASE_PED_WALK = 3'd6,
    PHASE_FLASH    = 3'd7
  } phase_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       walk;
  } lamps_t;

  // Moore lamp decode; lit selects the lit/dark half of the night flash.
  function automatic lamps_t lamps_of(phase_t ph, logic lit);
    lamps_t l;
    l.main_lamp = LIGHT_RED;
    l.side_lamp = LIGHT_RED;
    l.walk      = 1'b0;
    case (ph)
      PHASE_MAIN_G:   l.main_lamp = LIGHT_GRN;
      PHASE_MAIN_Y:   l.main_lamp = LIGHT_YEL;
      PHASE_SIDE_G:   l.side_lamp = LIGHT_GRN;
      PHASE_SIDE_Y:   l.side_lamp = LIGHT_YEL;
      PHASE_PED_WALK: l.walk      = 1'b1;
      PHASE_FLASH:    l.main_lamp = lit ? LIGHT_YEL : LIGHT_OFF;
      default:        l.main_lamp = LIGHT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter that times every phase and the flash half-period.
// Holds at zero; the controller always reloads it before it would underflow.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Load on phase entry, otherwise count down towards zero.
  always_ff @(posedge clk) begin
    if (load) begin
      count_r <= load_val;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with pedestrian phase and night flash.
// All lamp outputs are registered and decoded from the next-state values.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 6,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);

  phase_t           state_r;
  phase_t           next_state_s;
  logic             lit_r;
  logic             next_lit_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             timer_load_s;
  logic [CNT_W-1:0] timer_val_s;
  logic             done_s;
  logic             ped_enter_s;
  lamps_t           next_lamps_s;

  assign timer_load_s = rst | load_s;
  assign timer_val_s  = rst ? GREEN_LD : load_val_s;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (done_s)
  );

  // Next phase and timer reload; flash is only honoured at the end of an all-red.
  always_comb begin
    next_state_s = state_r;
    next_lit_s   = lit_r;
    load_s       = 1'b0;
    load_val_s   = {CNT_W{1'b0}};
    case (state_r)
      PHASE_MAIN_G: begin
        if (done_s) begin
          next_state_s = PHASE_MAIN_Y;   load_s = 1'b1; load_val_s = YELLOW_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_MAIN_Y: begin
        if (done_s) begin
          next_state_s = PHASE_ALLRED_A; load_s = 1'b1; load_val_s = ALLRED_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_ALLRED_A: begin
        if (done_s && flash_en) begin
          next_state_s = PHASE_FLASH;    load_s = 1'b1; load_val_s = FLASH_LD; next_lit_s = 1'b1;
        end else if (done_s) begin
          next_state_s = PHASE_SIDE_G;   load_s = 1'b1; load_val_s = GREEN_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_SIDE_G: begin
        if (done_s) begin
          next_state_s = PHASE_SIDE_Y;   load_s = 1'b1; load_val_s = YELLOW_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_SIDE_Y: begin
        if (done_s) begin
          next_state_s = PHASE_ALLRED_B; load_s = 1'b1; load_val_s = ALLRED_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_ALLRED_B: begin
        if (done_s && flash_en) begin
          next_state_s = PHASE_FLASH;    load_s = 1'b1; load_val_s = FLASH_LD; next_lit_s = 1'b1;
        end else if (done_s && ped_pending) begin
          next_state_s = PHASE_PED_WALK; load_s = 1'b1; load_val_s = PED_LD;
        end else if (done_s) begin
          next_state_s = PHASE_MAIN_G;   load_s = 1'b1; load_val_s = GREEN_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_PED_WALK: begin
        if (done_s) begin
          next_state_s = PHASE_MAIN_G;   load_s = 1'b1; load_val_s = GREEN_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      PHASE_FLASH: begin
        // Leaving flash is immediate; the all-red clearance follows in full.
        if (!flash_en) begin
          next_state_s = PHASE_ALLRED_B; load_s = 1'b1; load_val_s = ALLRED_LD; next_lit_s = 1'b1;
        end else if (done_s) begin
          next_lit_s   = ~lit_r;         load_s = 1'b1; load_val_s = FLASH_LD;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = PHASE_MAIN_G;     load_s = 1'b1; load_val_s = GREEN_LD; next_lit_s = 1'b1;
      end
    endcase
  end

  assign ped_enter_s  = (next_state_s == PHASE_PED_WALK) && (state_r != PHASE_PED_WALK);
  assign next_lamps_s = lamps_of(next_state_s, next_lit_s);
  assign phase        = state_r;

  // State, flash toggle, registered lamps and the pedestrian latch (clear beats set).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PHASE_MAIN_G;
      lit_r       <= 1'b1;
      main_light  <= LIGHT_GRN;
      side_light  <= LIGHT_RED;
      ped_walk    <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      lit_r       <= next_lit_s;
      main_light  <= next_lamps_s.main_lamp;
      side_light  <= next_lamps_s.side_lamp;
      ped_walk    <= next_lamps_s.walk;
      if (ped_enter_s) begin
        ped_pending <= 1'b0;
      end else if (ped_req && (state_r != PHASE_PED_WALK)) begin
        ped_pending <= 1'b1;
      end else begin
        ped_pending <= ped_pending;
      end
    end
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed, table-driven bench for traffic_intersection_ctrl plus a random
// soak that checks the lamp safety invariants and exact phase durations.
module tb_traffic_intersection_ctrl;

  logic       clk;
  logic       rst;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] main_light, side_light, phase;
  logic       ped_walk, ped_pending;
  logic [2:0] f_main, f_side, f_phase;
  logic       f_walk, f_pend;

  int checks = 0;
  int errors = 0;

  traffic_intersection_ctrl dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  traffic_intersection_ctrl #(.GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1)) dut_fast (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .main_light(f_main), .side_light(f_side), .ped_walk(f_walk),
    .ped_pending(f_pend), .phase(f_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         restart;
    int         tid;
    int         n;
    logic       r, p, f;
    logic [2:0] em, es;
    logic       ew, ep;
    logic [2:0] eph;
  } seg_t;

  seg_t tbl[$];

  function automatic seg_t mk(bit rs, int tid, int n, logic r, logic p, logic f,
                              logic [2:0] em, logic [2:0] es, logic ew, logic ep, logic [2:0] eph);
    seg_t s;
    s.restart = rs; s.tid = tid; s.n = n; s.r = r; s.p = p; s.f = f;
    s.em = em; s.es = es; s.ew = ew; s.ep = ep; s.eph = eph;
    return s;
  endfunction

  function automatic int dur_of(logic [2:0] ph);
    case (ph)
      3'd0, 3'd3: return 8;
      3'd1, 3'd4: return 3;
      3'd2, 3'd5: return 2;
      3'd6:       return 6;
      default:    return 0;
    endcase
  endfunction

  function automatic bit inv_ok(logic [2:0] m, logic [2:0] s, logic w, logic [2:0] ph);
    bit ok;
    ok = !((m != 3'b100) && (s != 3'b100));
    ok = ok && (!w || ((m == 3'b100) && (s == 3'b100)));
    ok = ok && $onehot(s) && ($onehot(m) || ((ph == 3'd7) && (m == 3'b000)));
    return ok;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step(input seg_t s, input int cyc);
    rst = s.r; ped_req = s.p; flash_en = s.f;
    @(negedge clk);
    checks++;
    if ({main_light, side_light, ped_walk, ped_pending, phase} !== {s.em, s.es, s.ew, s.ep, s.eph}) begin
      errors++;
      $display("FAIL test%0d cycle %0d: got main=%b side=%b walk=%b pend=%b phase=%0d, want main=%b side=%b walk=%b pend=%b phase=%0d",
               s.tid, cyc, main_light, side_light, ped_walk, ped_pending, phase,
               s.em, s.es, s.ew, s.ep, s.eph);
    end
    @(posedge clk); #1;
  endtask

  logic [2:0] fast_main[6];
  logic [2:0] fast_side[6];
  logic [2:0] prev_ph;
  int         run;
  int         cyc;

  initial begin
    rst = 1'b1; ped_req = 1'b0; flash_en = 1'b0;

    // Test 1: default sequence, period 26
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 3'b010, 3'b100, 0, 0, 3'd1));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 3'b100, 3'b100, 0, 0, 3'd2));
    tbl.push_back(mk(0, 1, 8, 0, 0, 0, 3'b100, 3'b001, 0, 0, 3'd3));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 3'b100, 3'b010, 0, 0, 3'd4));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 3'b100, 3'b100, 0, 0, 3'd5));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    // Test 2: pedestrian pulse at cycle 3, ignored pulse at cycle 28
    tbl.push_back(mk(1, 2, 3, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 2, 1, 0, 1, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 2, 4, 0, 0, 0, 3'b001, 3'b100, 0, 1, 3'd0));
    tbl.push_back(mk(0, 2, 3, 0, 0, 0, 3'b010, 3'b100, 0, 1, 3'd1));
    tbl.push_back(mk(0, 2, 2, 0, 0, 0, 3'b100, 3'b100, 0, 1, 3'd2));
    tbl.push_back(mk(0, 2, 8, 0, 0, 0, 3'b100, 3'b001, 0, 1, 3'd3));
    tbl.push_back(mk(0, 2, 3, 0, 0, 0, 3'b100, 3'b010, 0, 1, 3'd4));
    tbl.push_back(mk(0, 2, 2, 0, 0, 0, 3'b100, 3'b100, 0, 1, 3'd5));
    tbl.push_back(mk(0, 2, 2, 0, 0, 0, 3'b100, 3'b100, 1, 0, 3'd6));
    tbl.push_back(mk(0, 2, 1, 0, 1, 0, 3'b100, 3'b100, 1, 0, 3'd6));
    tbl.push_back(mk(0, 2, 3, 0, 0, 0, 3'b100, 3'b100, 1, 0, 3'd6));
    tbl.push_back(mk(0, 2, 2, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    // Test 3: flash requested mid-green, taken after ALLRED_A, dropped at cycle 25
    tbl.push_back(mk(1, 3, 5, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 3, 3, 0, 0, 1, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 3, 3, 0, 0, 1, 3'b010, 3'b100, 0, 0, 3'd1));
    tbl.push_back(mk(0, 3, 2, 0, 0, 1, 3'b100, 3'b100, 0, 0, 3'd2));
    tbl.push_back(mk(0, 3, 4, 0, 0, 1, 3'b010, 3'b100, 0, 0, 3'd7));
    tbl.push_back(mk(0, 3, 4, 0, 0, 1, 3'b000, 3'b100, 0, 0, 3'd7));
    tbl.push_back(mk(0, 3, 4, 0, 0, 1, 3'b010, 3'b100, 0, 0, 3'd7));
    tbl.push_back(mk(0, 3, 1, 0, 0, 0, 3'b000, 3'b100, 0, 0, 3'd7));
    tbl.push_back(mk(0, 3, 2, 0, 0, 0, 3'b100, 3'b100, 0, 0, 3'd5));
    tbl.push_back(mk(0, 3, 2, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    // Test 4: reset mid SIDE_G with a pending request
    tbl.push_back(mk(1, 4, 1, 0, 1, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4, 7, 0, 0, 0, 3'b001, 3'b100, 0, 1, 3'd0));
    tbl.push_back(mk(0, 4, 3, 0, 0, 0, 3'b010, 3'b100, 0, 1, 3'd1));
    tbl.push_back(mk(0, 4, 2, 0, 0, 0, 3'b100, 3'b100, 0, 1, 3'd2));
    tbl.push_back(mk(0, 4, 2, 0, 0, 0, 3'b100, 3'b001, 0, 1, 3'd3));
    tbl.push_back(mk(0, 4, 1, 1, 0, 0, 3'b100, 3'b001, 0, 1, 3'd3));
    tbl.push_back(mk(0, 4, 8, 0, 0, 0, 3'b001, 3'b100, 0, 0, 3'd0));
    tbl.push_back(mk(0, 4, 1, 0, 0, 0, 3'b010, 3'b100, 0, 0, 3'd1));

    cyc = 0;
    foreach (tbl[i]) begin
      if (tbl[i].restart) begin
        do_reset();
        cyc = 0;
      end
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i], cyc);
        cyc++;
      end
    end

    // Test 5: one-cycle green/yellow/all-red instance, 6-cycle period
    fast_main = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    fast_side = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      checks++;
      if ({f_main, f_side, f_walk, f_phase} !== {fast_main[k % 6], fast_side[k % 6], 1'b0, 3'(k % 6)}) begin
        errors++;
        $display("FAIL fast cycle %0d: got main=%b side=%b walk=%b phase=%0d, want main=%b side=%b walk=0 phase=%0d",
                 k, f_main, f_side, f_walk, f_phase, fast_main[k % 6], fast_side[k % 6], k % 6);
      end
      @(posedge clk); #1;
    end

    // Test 6: random soak with invariant and duration checks
    do_reset();
    prev_ph = 3'd0;
    run = 0;
    for (int i = 0; i < 10000; i++) begin
      ped_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) flash_en = ~flash_en;
      @(negedge clk);
      checks += 2;
      if (!inv_ok(main_light, side_light, ped_walk, phase)) begin
        errors++;
        $display("FAIL invariant cycle %0d: main=%b side=%b walk=%b phase=%0d", i, main_light, side_light, ped_walk, phase);
      end
      if (!inv_ok(f_main, f_side, f_walk, f_phase)) begin
        errors++;
        $display("FAIL fast_invariant cycle %0d: main=%b side=%b walk=%b phase=%0d", i, f_main, f_side, f_walk, f_phase);
      end
      if (phase != prev_ph) begin
        if (dur_of(prev_ph) != 0) begin
          checks++;
          if (run != dur_of(prev_ph)) begin
            errors++;
            $display("FAIL duration cycle %0d: phase %0d lasted %0d, want %0d", i, prev_ph, run, dur_of(prev_ph));
          end
        end
        prev_ph = phase;
        run = 1;
      end else begin
        run++;
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
